// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit add split into STAGES chunks, one per clock.
// Optional subtract mode under `PIPELINED_RIPPLE_ADDER_SUB_EN` (adds the `sub` input).
module pipelined_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Per-stage registers: operands are kept right-aligned (next chunk at bit 0),
  // sum chunks enter at the top and shift down so the last stage holds the full sum.
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  ra [STAGES];
  logic [WIDTH-1:0]  rb [STAGES];
  logic [WIDTH-1:0]  rs [STAGES];
  logic [STAGES-1:0] rc;
  logic              ovf_q;

  logic [STAGES-1:0] sv;
  logic [STAGES-1:0] sc;
  logic [STAGES-1:0] nc;
  logic [WIDTH-1:0]  sa [STAGES];
  logic [WIDTH-1:0]  sb [STAGES];
  logic [WIDTH-1:0]  ss [STAGES];
  logic [WIDTH-1:0]  na [STAGES];
  logic [WIDTH-1:0]  nb [STAGES];
  logic [WIDTH-1:0]  ns [STAGES];
  logic [CW:0]       t  [STAGES];
  logic              novf;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
  // a - b - cin == a + ~b + ~cin
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = cin ^ sub;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  always_comb begin
    sv[0] = in_valid;
    sa[0] = a;
    sb[0] = b_eff;
    ss[0] = '0;
    sc[0] = cin_eff;
    for (int k = 1; k < STAGES; k++) begin
      sv[k] = vld[k-1];
      sa[k] = ra[k-1];
      sb[k] = rb[k-1];
      ss[k] = rs[k-1];
      sc[k] = rc[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      t[k]  = {1'b0, sa[k][CW-1:0]} + {1'b0, sb[k][CW-1:0]} + {{CW{1'b0}}, sc[k]};
      na[k] = sa[k] >> CW;
      nb[k] = sb[k] >> CW;
      ns[k] = (ss[k] >> CW) | (WIDTH'(t[k][CW-1:0]) << (WIDTH - CW));
      nc[k] = t[k][CW];
    end
    // carry into MSB is recovered from the MSB sum bit and the operand MSBs
    novf = sa[STAGES-1][CW-1] ^ sb[STAGES-1][CW-1] ^ t[STAGES-1][CW-1] ^ t[STAGES-1][CW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      rc    <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
        rs[k] <= '0;
      end
    end else if (adv) begin
      vld <= sv;
      // last stage doubles as the output register: it only loads real beats
      for (int k = 0; k < STAGES; k++) begin
        if (k < STAGES - 1 || sv[k]) begin
          ra[k] <= na[k];
          rb[k] <= nb[k];
          rs[k] <= ns[k];
          rc[k] <= nc[k];
        end
      end
      if (sv[STAGES-1]) ovf_q <= novf;
    end
  end

  assign out_valid = vld[STAGES-1];
  assign sum       = rs[STAGES-1];
  assign cout      = rc[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench for pipelined_ripple_adder (WIDTH=16, STAGES=4).
module tb_pipelined_ripple_adder;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic        has_exp;
    logic [15:0] esum;
    logic        ecout, eovf;
  } stim_t;

  typedef struct {
    logic [15:0] a, b;
    logic [15:0] sum;
    logic        cout, ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, sub;
  logic [15:0] a, b, sum;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int n_chk = 0, n_fail = 0;
  int cyc_n = 0, pops = 0, acc_cnt = 0, stall_left = 0;
  bit chk_lat = 0, rand_rdy = 0, rand_vld = 0, arm_stall = 0, stall_done = 0, pend = 0;

  pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed overflow as range check
  function automatic exp_t model(input stim_t s, input int acc);
    exp_t e;
    int r, sr;
    if (s.sub) begin
      r  = int'(s.a) - int'(s.b) - int'(s.cin);
      sr = int'($signed(s.a)) - int'($signed(s.b)) - int'(s.cin);
      e.cout = (r >= 0);
    end else begin
      r  = int'(s.a) + int'(s.b) + int'(s.cin);
      sr = int'($signed(s.a)) + int'($signed(s.b)) + int'(s.cin);
      e.cout = (r > 65535);
    end
    e.sum = r[15:0];
    e.ovf = (sr > 32767) || (sr < -32768);
    e.a   = s.a;
    e.b   = s.b;
    e.acc = acc;
    if (s.has_exp) begin
      e.sum  = s.esum;
      e.cout = s.ecout;
      e.ovf  = s.eovf;
    end
    return e;
  endfunction

  function automatic stim_t mk(input logic [15:0] sa, sb, input logic scin, ssub);
    stim_t s;
    s.a = sa; s.b = sb; s.cin = scin; s.sub = ssub;
    s.has_exp = 1'b0; s.esum = '0; s.ecout = 1'b0; s.eovf = 1'b0;
    return s;
  endfunction

  task automatic send_dir(input logic [15:0] sa, sb, input logic scin, ssub,
                          input logic [15:0] es, input logic ec, eo);
    stim_t s;
    s = mk(sa, sb, scin, ssub);
    s.has_exp = 1'b1; s.esum = es; s.ecout = ec; s.eovf = eo;
    stim_q.push_back(s);
  endtask

  task automatic check(input string name, input logic [31:0] got, exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One clock of driving: out_ready policy, then present/hold the head beat
  task automatic step();
    @(negedge clk);
    cyc_n++;
    if (arm_stall && !stall_done && pops > 0) begin
      stall_left = 3;
      stall_done = 1;
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (!pend) begin
      if (stim_q.size() > 0 && (!rand_vld || $urandom_range(0, 2) != 0)) begin
        a = stim_q[0].a; b = stim_q[0].b; cin = stim_q[0].cin; sub = stim_q[0].sub;
        in_valid = 1'b1;
        pend = 1;
      end else begin
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      end
    end
    #1;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(stim_q[0], cyc_n));
      void'(stim_q.pop_front());
      pend = 0;
      acc_cnt++;
    end
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && n < lim) begin
      step();
      n++;
    end
    n_chk++;
    if (stim_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d stimuli and %0d results outstanding, expected 0",
               stim_q.size(), exp_q.size());
    end
  endtask

  // Monitor: compares whenever the DUT presents a result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got sum=%h with no beat outstanding", sum);
        end else begin
          e = exp_q[0];
          if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL result a=%h b=%h: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     e.a, e.b, sum, cout, ovf, e.sum, e.cout, e.ovf);
          end
          if (!out_ready) begin
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
          end else begin
            if (chk_lat) check("latency", cyc_n - e.acc, 32'd4);
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, a0, n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_sum", {16'b0, sum}, 32'd0);
    check("reset_cout_ovf", {30'b0, cout, ovf}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed adds with exact latency
    chk_lat = 1;
    send_dir(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);
    send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_dir(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_dir(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    drain(100);
    chk_lat = 0;

    // Backpressure: 8 back-to-back beats, 3-cycle stall after first result
    p0 = pops;
    arm_stall = 1; stall_done = 0;
    for (int i = 0; i < 8; i++) stim_q.push_back(mk(16'(i), 16'(i * 256), 1'b0, 1'b0));
    drain(200);
    arm_stall = 0;
    check("backpressure_count", pops - p0, 32'd8);

    // Reset with three beats in flight
    a0 = acc_cnt;
    for (int i = 1; i <= 3; i++) stim_q.push_back(mk(16'(i * 4369), 16'h0101, 1'b1, 1'b0));
    n = 0;
    while (acc_cnt - a0 < 3 && n < 20) begin
      step();
      n++;
    end
    check("midflight_accepted", acc_cnt - a0, 32'd3);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; pend = 0;
    #1;
    check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset_sum", {16'b0, sum}, 32'd0);
    exp_q.delete();
    stim_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      step();
      check("post_reset_idle", {31'b0, out_valid}, 32'd0);
    end

`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
    send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_dir(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    drain(100);
`endif

    // Randomized traffic with random gaps and backpressure
    rand_rdy = 1; rand_vld = 1;
    for (int i = 0; i < 300; i++) begin
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
      stim_q.push_back(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)));
`else
      stim_q.push_back(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'b0));
`endif
    end
    drain(5000);
    rand_rdy = 0; rand_vld = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
